// File: rtl/two_bit_product_accumulator_if.sv
// Handshake bundle between the multiplier issue side and the product accumulator.
interface two_bit_product_accumulator_if #(
    parameter int a_N   = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic                 start;
    logic [LEN_W-1:0]     len;
    logic                 busy;
    logic [2*a_N-1:0]     in_prod;
    logic                 in_vld;
    logic                 in_rdy;
    logic [ACC_W-1:0]     acc_out;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 ovf;

    // Producer/consumer side driving the reduction.
    modport master (
        output start, len, in_prod, in_vld, out_rdy,
        input  busy, in_rdy, acc_out, out_vld, ovf
    );

    // Accumulator side.
    modport slave (
        input  start, len, in_prod, in_vld, out_rdy,
        output busy, in_rdy, acc_out, out_vld, ovf
    );
endinterface

// File: rtl/two_bit_product_accumulator.sv
// Accumulates exactly len signed partial products into a wrapping ACC_W-bit sum,
// then holds the result on a valid/ready output while stalling the input.
// Module parameters must match those of the connected interface instance.
module two_bit_product_accumulator #(
    parameter int a_N   = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input logic clk,
    input logic rst,
    two_bit_product_accumulator_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic             last_beat;

    assign prod_ext  = ACC_W'($signed(bus.in_prod));
    assign sum       = acc_q + prod_ext;
    // Same-sign addends producing an opposite-sign result.
    assign add_ovf   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != acc_q[ACC_W-1]);
    // len_q is never zero in ACCUM, so len_q-1 cannot underflow there.
    assign last_beat = (count_q == len_q - LEN_W'(1));

    // Outputs decoded from registered state only.
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.in_rdy  = (state_q == ST_ACCUM);
    assign bus.out_vld = (state_q == ST_HOLD);
    assign bus.acc_out = acc_q;
    assign bus.ovf     = ovf_q;

    // Next-state: start in IDLE, accumulate beats in ACCUM, drain in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.in_vld) begin
                    acc_d   = sum;
                    count_d = count_q + LEN_W'(1);
                    if (add_ovf) ovf_d = 1'b1;
                    if (last_beat) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_two_bit_product_accumulator.sv
// Randomized self-checking bench for two_bit_product_accumulator (ACC_W=33 so wrap is reachable).
module tb_two_bit_product_accumulator;
    localparam int AN = 16;
    localparam int AW = 33;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] prod_q[$];

    two_bit_product_accumulator_if #(.a_N(AN), .ACC_W(AW), .LEN_W(LW)) bus ();

    two_bit_product_accumulator #(.a_N(AN), .ACC_W(AW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum, wrapped into the signed 33-bit range after each add.
    function automatic void model(input int n, output logic [32:0] acc, output bit ovf);
        longint a = 0;
        longint s;
        longint p;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(prod_q[i]));
            s = a + p;
            if (s > 64'sd4294967295 || s < -64'sd4294967296) ovf = 1'b1;
            s = s & 64'sh1_FFFF_FFFF;
            if (s >= 64'sd4294967296) s = s - 64'sd8589934592;
            a = s;
        end
        acc = a[32:0];
    endfunction

    // One full reduction: start, n beats (optional gaps), hold cycles under backpressure, drain.
    task automatic run(input int n, input bit gaps, input int hold, input bit poke);
        logic [32:0] e_acc;
        bit          e_ovf;
        logic [31:0] nn;
        model(n, e_acc, e_ovf);
        nn = n;
        check("idle_busy", bus.busy, 0);
        check("idle_in_rdy", bus.in_rdy, 0);
        bus.start = 1'b1;
        bus.len   = nn[7:0];
        tick();
        bus.start = poke;
        bus.len   = 8'd9;
        check("busy_after_start", bus.busy, 1);
        if (n == 0) begin
            check("zero_len_vld", bus.out_vld, 1);
            check("zero_len_acc", bus.acc_out, 0);
        end else begin
            check("accum_in_rdy", bus.in_rdy, 1);
            for (int i = 0; i < n; i++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.in_vld  = 1'b0;
                        bus.in_prod = $urandom;
                        tick();
                        check("gap_in_rdy", bus.in_rdy, 1);
                        check("gap_out_vld", bus.out_vld, 0);
                    end
                end
                bus.in_vld  = 1'b1;
                bus.in_prod = prod_q[i];
                tick();
                bus.in_vld = 1'b0;
                check("out_vld_latency", bus.out_vld, (i == n - 1));
            end
        end
        repeat (hold) begin
            bus.out_rdy = 1'b0;
            bus.in_vld  = 1'b1;
            bus.in_prod = 32'd100;
            tick();
            check("hold_out_vld", bus.out_vld, 1);
            check("hold_in_rdy", bus.in_rdy, 0);
            check("hold_acc", bus.acc_out, e_acc);
        end
        bus.in_vld = 1'b0;
        check("acc_out", bus.acc_out, e_acc);
        check("ovf", bus.ovf, e_ovf);
        check("hold_in_rdy_final", bus.in_rdy, 0);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        bus.start   = 1'b0;
        check("drain_out_vld", bus.out_vld, 0);
        check("drain_busy", bus.busy, 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.in_prod = '0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_acc", bus.acc_out, 0);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_in_rdy", bus.in_rdy, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        tick();

        // Basic sum.
        prod_q = '{32'd3, 32'd5, 32'hFFFF_FFFE, 32'd10};
        run(4, 1'b0, 0, 1'b0);
        check("basic_const", bus.acc_out, 33'd16);

        // Gaps and 5 cycles of backpressure.
        prod_q = '{32'd1, 32'd2, 32'd4};
        run(3, 1'b1, 5, 1'b0);
        check("gap_const", bus.acc_out, 33'd7);

        // Zero length.
        prod_q = {};
        run(0, 1'b0, 2, 1'b0);

        // Overflow then a clean follow-up run.
        prod_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run(3, 1'b0, 1, 1'b0);
        check("ovf_wrap_const", bus.acc_out, 33'h1_7FFF_FFFD);
        check("ovf_sticky", bus.ovf, 1);
        prod_q = '{32'd1};
        run(1, 1'b0, 0, 1'b0);
        check("ovf_cleared", bus.ovf, 0);

        // Reset in the middle of a reduction.
        bus.start = 1'b1;
        bus.len   = 8'd5;
        tick();
        bus.start = 1'b0;
        repeat (2) begin
            bus.in_vld  = 1'b1;
            bus.in_prod = 32'h7FFF_0000;
            tick();
        end
        bus.in_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_acc", bus.acc_out, 0);
        check("midrst_in_rdy", bus.in_rdy, 0);
        check("midrst_out_vld", bus.out_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        prod_q = '{32'd7};
        run(1, 1'b0, 0, 1'b0);
        check("after_rst_const", bus.acc_out, 33'd7);

        // start pulsed during ACCUM and HOLD is ignored.
        prod_q = '{$urandom, $urandom};
        run(2, 1'b1, 2, 1'b1);
        tick();
        check("poke_still_idle", bus.busy, 0);

        // Maximum length must not terminate early.
        prod_q = {};
        for (int i = 0; i < 255; i++) prod_q.push_back($urandom);
        run(255, 1'b0, 0, 1'b0);

        // Randomized reductions.
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(0, 6);
            prod_q = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) prod_q.push_back($urandom);
                else begin
                    int v;
                    v = int'($urandom_range(0, 200)) - 100;
                    prod_q.push_back(v);
                end
            end
            run(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
